// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register_block write port between two writeback requesters.
// Grants are combinational; the winning write is registered onto the port for one cycle.
module reg_write_arbiter #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  req0_valid,
    input  logic [ID_WIDTH-1:0]   req0_id,
    input  logic [DATA_WIDTH-1:0] req0_value,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ID_WIDTH-1:0]   req1_id,
    input  logic [DATA_WIDTH-1:0] req1_value,
    output logic                  req1_ready,
    output logic                  write_enable,
    output logic [ID_WIDTH-1:0]   write_id,
    output logic [DATA_WIDTH-1:0] write_value,
    output logic                  last_grant,
    output logic                  bad_id,
    output logic [7:0]            write_count
);

    localparam int unsigned CNT_WIDTH = 8;
    // One extra bit so NUM_REGS == 2**ID_WIDTH still compares correctly.
    localparam logic [ID_WIDTH:0] NUM_REGS_EXT = (ID_WIDTH + 1)'(NUM_REGS);

    logic                  prio;
    logic                  grant;
    logic                  grant_idx;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [DATA_WIDTH-1:0] grant_value;
    logic                  id_ok;
    logic                  commit;

    // Round-robin grant: the requester that did not win last has priority on a tie.
    always_comb begin
        prio        = ~last_grant;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        if (!hold && !reset) begin
            req0_ready = req0_valid && (!req1_valid || (prio == 1'b0));
            req1_ready = req1_valid && (!req0_valid || (prio == 1'b1));
        end
        grant       = req0_ready || req1_ready;
        grant_idx   = req1_ready;
        grant_id    = req1_ready ? req1_id    : req0_id;
        grant_value = req1_ready ? req1_value : req0_value;
        id_ok       = ({1'b0, grant_id} < NUM_REGS_EXT);
        commit      = grant && id_ok;
    end

    // Write port, pointer, sticky error and commit counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable <= 1'b0;
            write_id     <= '0;
            write_value  <= '0;
            last_grant   <= 1'b1;
            bad_id       <= 1'b0;
            write_count  <= '0;
        end else begin
            write_enable <= commit;
            if (commit) begin
                write_id    <= grant_id;
                write_value <= grant_value;
                write_count <= write_count + CNT_WIDTH'(1);
            end
            if (grant) begin
                last_grant <= grant_idx;
            end
            if (grant && !id_ok) begin
                bad_id <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed stimulus pushes expected writes,
// an independent monitor pops and compares whenever write_enable is seen.
module tb_reg_write_arbiter;

    logic       clock;
    logic       reset;
    logic       hold;
    logic       req0_valid;
    logic [3:0] req0_id;
    logic [7:0] req0_value;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_id;
    logic [7:0] req1_value;
    logic       req1_ready;
    logic       write_enable;
    logic [3:0] write_id;
    logic [7:0] write_value;
    logic       last_grant;
    logic       bad_id;
    logic [7:0] write_count;

    reg_write_arbiter #(.ID_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(12)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .req0_valid(req0_valid), .req0_id(req0_id), .req0_value(req0_value), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_id(req1_id), .req1_value(req1_value), .req1_ready(req1_ready),
        .write_enable(write_enable), .write_id(write_id), .write_value(write_value),
        .last_grant(last_grant), .bad_id(bad_id), .write_count(write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] id;
        logic [7:0] val;
        logic [7:0] cnt;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] exp_count = 8'd0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented write against the scoreboard head.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (write_enable === 1'b1) begin
                if (q.size() == 0) begin
                    cmp("unexpected_write", 32'(write_id), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    cmp("write_id",    32'(write_id),    32'(e.id));
                    cmp("write_value", 32'(write_value), 32'(e.val));
                    cmp("write_count", 32'(write_count), 32'(e.cnt));
                    cmp("write_cycle", 32'(cyc),         32'(e.due));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                cmp("missing_write", 32'(write_enable), 32'd1);
            end
        end
    end

    // One stimulus cycle: drive after the falling edge, check readys, record expected write.
    task automatic drive(input logic rst, input logic hld,
                         input logic v0, input logic [3:0] i0, input logic [7:0] d0,
                         input logic v1, input logic [3:0] i1, input logic [7:0] d1,
                         input logic e0, input logic e1, input string tag);
        logic [3:0] gid;
        @(negedge clock);
        reset = rst; hold = hld;
        req0_valid = v0; req0_id = i0; req0_value = d0;
        req1_valid = v1; req1_id = i1; req1_value = d1;
        #1;
        cmp({tag, "_ready0"}, 32'(req0_ready), 32'(e0));
        cmp({tag, "_ready1"}, 32'(req1_ready), 32'(e1));
        if (rst) begin
            exp_count = 8'd0;
        end else if (e0 || e1) begin
            gid = e1 ? i1 : i0;
            if (gid < 4'd12) begin
                exp_count = exp_count + 8'd1;
                q.push_back('{id: gid, val: (e1 ? d1 : d0), cnt: exp_count, due: cyc + 1});
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "idle");
    endtask

    // Registered state checked just after the edge that the previous drive() set up.
    task automatic post(input string tag, input logic we, input logic lg,
                        input logic bad, input logic [7:0] cnt);
        @(posedge clock);
        #2;
        cmp({tag, "_write_enable"}, 32'(write_enable), 32'(we));
        cmp({tag, "_last_grant"},   32'(last_grant),   32'(lg));
        cmp({tag, "_bad_id"},       32'(bad_id),       32'(bad));
        cmp({tag, "_write_count"},  32'(write_count),  32'(cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_val;
        reset = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req0_id = 4'd0; req0_value = 8'd0;
        req1_valid = 1'b0; req1_id = 4'd0; req1_value = 8'd0;

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "rst");
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "rst");
        post("reset", 1'b0, 1'b1, 1'b0, 8'd0);
        cmp("reset_write_id",    32'(write_id),    32'd0);
        cmp("reset_write_value", 32'(write_value), 32'd0);

        // Single req0 write
        drive(1'b0, 1'b0, 1'b1, 4'd2, 8'h55, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "single");
        post("single", 1'b1, 1'b0, 1'b0, 8'd1);
        idle();

        // Both valid: strict alternation starting at req0
        drive(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "rst");
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b1, 1'b0, "rr0");
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b1, "rr1");
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b1, 1'b0, "rr2");
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b1, "rr3");
        post("rr", 1'b1, 1'b1, 1'b0, 8'd4);

        // Hold freezes the pointer; priority resumes with req1
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b1, 1'b0, "pre_hold");
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, "hold0");
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, "hold1");
        drive(1'b0, 1'b1, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b0, "hold2");
        post("hold", 1'b0, 1'b0, 1'b0, 8'd5);
        drive(1'b0, 1'b0, 1'b1, 4'd3, 8'hA0, 1'b1, 4'd4, 8'h0B, 1'b0, 1'b1, "release");
        post("release", 1'b1, 1'b1, 1'b0, 8'd6);

        // Nonexistent register id is consumed and flagged
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd14, 8'hFF, 1'b0, 1'b1, "bad");
        post("bad", 1'b0, 1'b1, 1'b1, 8'd6);
        drive(1'b0, 1'b0, 1'b1, 4'd5, 8'h33, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "after_bad");
        post("after_bad", 1'b1, 1'b0, 1'b1, 8'd7);

        // Grant suppressed in a reset cycle
        drive(1'b1, 1'b0, 1'b1, 4'd6, 8'h77, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "rst_grant");
        post("rst_grant", 1'b0, 1'b1, 1'b0, 8'd0);

        // 256 commits wrap the counter back to zero
        last_val = 8'd0;
        for (int i = 0; i < 256; i++) begin
            last_val = 8'(i) ^ 8'h3C;
            drive(1'b0, 1'b0, 1'b1, 4'd1, last_val, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "wrap");
        end
        post("wrap", 1'b1, 1'b0, 1'b0, 8'd0);
        cmp("wrap_last_value", 32'(write_value), 32'(last_val));
        idle();
        idle();
        idle();
        @(posedge clock);
        #3;
        cmp("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of register_block between two writeback requesters: req0 (ALU result) and req1 (load/immediate path).
- Grants one request per cycle under round-robin priority.
- Registers the winning id/value onto the register_block write port for exactly one cycle.
- Screens out ids that name nonexistent registers and keeps a sticky error flag plus a wrapping write counter for debug.

Parameters:
- ID_WIDTH, 4, width of register ids.
- DATA_WIDTH, 8, width of register values.
- NUM_REGS, 12, count of implemented registers; ids >= NUM_REGS are nonexistent.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hold  input  1  controller stall; while 1, no request is granted.
- req0_valid  input  1  requester 0 has a write pending.
- req0_id  input  ID_WIDTH  target register for requester 0.
- req0_value  input  DATA_WIDTH  data for requester 0.
- req0_ready  output  1  requester 0 granted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_id  input  ID_WIDTH  target register for requester 1.
- req1_value  input  DATA_WIDTH  data for requester 1.
- req1_ready  output  1  requester 1 granted this cycle (combinational).
- write_enable  output  1  registered; drives the register_block write strobe.
- write_id  output  ID_WIDTH  registered; to register_block write_id.
- write_value  output  DATA_WIDTH  registered; to register_block write_value.
- last_grant  output  1  registered; requester index of the most recent grant.
- bad_id  output  1  sticky; set when a granted request targeted id >= NUM_REGS.
- write_count  output  8  registered; count of committed writes, wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high. All state updates on the rising edge of clock.
- Reset values: write_enable=0, write_id=0, write_value=0, last_grant=1 (so req0 has first priority), bad_id=0, write_count=0.
- Priority pointer: prio = ~last_grant.
- Grant, combinational, same cycle:
  - hold=1 or reset=1 -> both readys 0.
  - Only one valid -> that requester ready.
  - Both valid -> requester prio ready, other 0.
  - Exactly one ready may be high at a time; ready never asserts without its valid.
- Handshake: transfer occurs when valid & ready at a rising edge. A requester not granted must hold valid, id and value stable until granted. The arbiter does not buffer ungranted requests.
- Latency: grant at edge N -> write_enable/write_id/write_value present during cycle N+1. The write lands in the register file per register_block timing.
- No-grant cycle: write_enable=0; write_id/write_value hold their previous values.
- last_grant: updates to the granted index only on a grant; otherwise holds. Fairness: with both valid continuously, grants strictly alternate, so neither requester waits more than 1 cycle.
- Bad id: a granted request with id >= NUM_REGS is consumed (ready=1) but produces write_enable=0. It sets bad_id=1, which stays set until reset, and does not increment write_count. last_grant still updates.
- write_count: +1 on every cycle write_enable will be 1 (registered with it), modulo 256.
- Same-id collision (both requesters valid, same id): no merging. Normal round-robin; the loser writes in a later cycle (last writer wins).
- hold asserted: no grants, pointer frozen. A write already registered still appears on the following cycle.
- Reset mid-operation: a grant in the reset cycle is suppressed. write_enable is 0 in the cycle after reset regardless of prior state.

Test Plan:
- Reset, then req0_valid=1, id=2, value=8'h55 for one cycle -> req0_ready=1 that cycle; next cycle write_enable=1, write_id=2, write_value=8'h55, last_grant=0, write_count=1.
- After reset, req0 (id=3, 8'hA0) and req1 (id=4, 8'h0B) both held valid -> grant order req0, req1, req0, req1 on consecutive cycles; write_count=4 after 4 grants.
- Both valid with hold=1 for 3 cycles -> readys 0 and write_enable 0 throughout. Release hold -> grant goes to the requester prio indicated before the hold.
- req1_valid=1, id=14, value=8'hFF -> req1_ready=1; next cycle write_enable=0, bad_id=1, write_count unchanged. A following valid write to id=5 -> write_enable=1 and bad_id still 1.
- Grant req0 in cycle N with reset=1 in cycle N -> req0_ready=0; cycle N+1 write_enable=0, write_count=0, last_grant=1.
- 256 single-requester writes to id=1 -> write_count wraps to 0 on the 256th commit; the final write_value matches the last stimulus value.
